ram_stream_reader: RTL and testbench

Read-side initiator for a simple synchronous RAM port with registered address and registered read data (fixed read latency). Accepts a burst command (start address, length) and walks the RAM, re-timing the returned words into a valid/ready output stream. Backpressure is handled with credit-limited issue into a small internal FIFO, so no word is ever lost or duplicated. Sits between any single-clock RAM read port and a streaming consumer, e.g. a DMA or config-dump path.

---
 rtl/ram_stream_reader_pkg.sv | 24 ++
 rtl/ram_stream_reader_if.sv | 35 +++
 rtl/ram_stream_fifo.sv | 72 +++++++
 rtl/ram_stream_reader.sv | 191 +++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// ram_stream_reader_pkg
//   Shared types and constants for the RAM stream reader.
//   - state_t           : burst controller states (IDLE, READ, DRAIN)
//   - ptr_width()       : FIFO pointer width for a given depth (clog2, min 1)
//   - FIFO_DEPTH_DEFAULT: default output FIFO depth
//   - FIFO_PTR_W        : pointer width for the default FIFO depth
// -----------------------------------------------------------------------------
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int FIFO_PTR_W         = ptr_width(FIFO_DEPTH_DEFAULT);

endpackage

// File: rtl/ram_stream_reader_if.sv
// -----------------------------------------------------------------------------
// ram_stream_reader_if
//   Bundles the command, RAM read port and output stream of the reader.
//   master : the reader itself (accepts commands, drives mem_addr, streams out)
//   slave  : its environment (command source, RAM, stream consumer)
//   Signals: cmd_valid/cmd_ready/cmd_addr/cmd_len, mem_addr/mem_data_out,
//            out_valid/out_ready/out_data/out_last, busy, done.
// -----------------------------------------------------------------------------
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 6
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH:0]   cmd_len;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, mem_data_out, out_ready,
        output cmd_ready, mem_addr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, mem_data_out, out_ready,
        input  cmd_ready, mem_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/ram_stream_fifo.sv
// -----------------------------------------------------------------------------
// ram_stream_fifo
//   Synchronous FIFO holding {last, data} words for the reader output.
//   Ports: clk, rst_n (async, active-low), push_i/data_i (write side),
//          pop_i/data_o (read side, data_o is the head entry),
//          count_o (occupancy 0..DEPTH), empty_o, full_o.
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ram_stream_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [PTR_W:0]   count_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; emptiness comes from the pointers/count and the head is gated by the consumer.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_MAX);
endmodule

// File: rtl/ram_stream_reader.sv
// -----------------------------------------------------------------------------
// ram_stream_reader
//   Burst read initiator for a fixed-latency synchronous RAM port. Walks the
//   RAM from cmd_addr for cmd_len words (address wraps) and re-times the data
//   into a valid/ready stream through a small FIFO. Reads are only issued while
//   in-flight reads plus buffered words leave room in the FIFO, so backpressure
//   never loses or duplicates a word.
//   Ports: clk, rst_n (async, active-low), bus (ram_stream_reader_if.master:
//          command, RAM read port, output stream, busy, done).
//   Optional: RAM_STREAM_READER_STALL_CNT_EN adds stall_cycles[15:0], a
//          saturating count of out_valid && !out_ready cycles, cleared on
//          command accept.
// -----------------------------------------------------------------------------
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 14,
    parameter int ADDR_WIDTH   = 6,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_stream_reader_if.master   bus
`ifdef RAM_STREAM_READER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);
    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LEN_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0]      LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]        remaining_q, remaining_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] lst_q;
    logic                    done_q, done_d;

    logic                    accept;
    logic                    issue;
    logic                    last_issue;
    logic                    push;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   fifo_data;
    logic                    fifo_last;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;

    assign accept = bus.cmd_valid && (state_q == IDLE);
    assign push   = vld_q[READ_LATENCY-1];
    assign pop    = !fifo_empty && bus.out_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        last_issue  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = READ;
                        addr_d      = bus.cmd_addr;
                        remaining_d = bus.cmd_len;
                    end
                end
            end
            READ: begin
                // Credit: every issued read owns a FIFO slot until it is popped.
                if ((inflight_q + fifo_count) < DEPTH_C) begin
                    issue       = 1'b1;
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        last_issue = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last-flagged word is the only one left once it is popped.
                if (pop && fifo_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------- counters and valid pipe
    always_comb begin
        inflight_d = inflight_q;
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= '0;
            vld_q       <= '0;
            lst_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
            // The bit leaving the pipe lines up with that read's data on mem_data_out.
            vld_q[0]    <= issue;
            lst_q[0]    <= last_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    // ------------------------------------------------------- output FIFO
    ram_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  ({lst_q[READ_LATENCY-1], bus.mem_data_out}),
        .pop_i   (pop),
        .data_o  ({fifo_last, fifo_data}),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

    // ------------------------------------------------------------ outputs
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = !fifo_empty;
    // Head gated so out_data/out_last read as zero whenever nothing is offered.
    assign bus.out_data  = fifo_empty ? '0 : fifo_data;
    assign bus.out_last  = !fifo_empty && fifo_last;

`ifdef RAM_STREAM_READER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if (!fifo_empty && !bus.out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_ram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_ram_stream_reader
//   Self-checking bench for ram_stream_reader. A behavioural model turns each
//   accepted command into the list of words that must appear on the stream;
//   one negedge process compares the DUT against it every cycle. Directed
//   scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_ram_stream_reader;
    localparam int DW       = 14;
    localparam int AW       = 6;
    localparam int READ_LAT = 2;
    localparam int DEPTH    = 4;
    localparam int RAM_SIZE = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef RAM_STREAM_READER_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    ram_stream_reader #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (READ_LAT),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.master)
`ifdef RAM_STREAM_READER_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // ------------------------------------------------------------ RAM model
    logic [DW-1:0] ram [RAM_SIZE];
    logic [DW-1:0] rd_pipe [READ_LAT];

    always @(posedge clk) begin
        rd_pipe[0] <= ram[bus.mem_addr];
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_data_out = rd_pipe[READ_LAT-1];

    // ---------------------------------------------------------- bookkeeping
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- ready driver
    int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ------------------------------------------------- model and comparator
    logic [DW:0] exp_q [$];   // {last, data} still owed to the consumer
    bit          active    = 1'b0;
    bit          done_pend = 1'b0;
    int          popped    = 0;
    bit          prev_stall = 1'b0;
    logic [DW:0] prev_word = '0;
    int          stall_exp = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                active     = 1'b0;
                done_pend  = 1'b0;
                popped     = 0;
                prev_stall = 1'b0;
                stall_exp  = 0;
            end else begin
                bit done_nxt;
                check("done", 32'(bus.done), 32'(done_pend));
                check("busy", 32'(bus.busy), 32'(active));
                check("cmd_ready", 32'(bus.cmd_ready), 32'(!active));
`ifdef RAM_STREAM_READER_STALL_CNT_EN
                check("stall_cycles", 32'(stall_cycles), 32'(stall_exp));
`endif
                if (prev_stall) begin
                    check("hold_valid", 32'(bus.out_valid), 32'd1);
                    check("hold_word", 32'({bus.out_last, bus.out_data}), 32'(prev_word));
                end
                if (!active) check("idle_valid", 32'(bus.out_valid), 32'd0);
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) check("unexpected_word", 32'(bus.out_valid), 32'd0);
                    else check("word", 32'({bus.out_last, bus.out_data}), 32'(exp_q[0]));
                end

                done_nxt = 1'b0;
                if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                    logic [DW:0] w;
                    w = exp_q.pop_front();
                    popped++;
                    if (w[DW]) begin
                        done_nxt = 1'b1;
                        active   = 1'b0;
                    end
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    int a, l;
                    a = int'(bus.cmd_addr);
                    l = int'(bus.cmd_len);
                    popped    = 0;
                    stall_exp = 0;
                    if (l == 0) begin
                        done_nxt = 1'b1;
                    end else begin
                        active = 1'b1;
                        for (int i = 0; i < l; i++) begin
                            logic lastb;
                            lastb = (i == l - 1);
                            exp_q.push_back({lastb, ram[(a + i) % RAM_SIZE]});
                        end
                    end
                end else if (bus.out_valid && !bus.out_ready && stall_exp != 16'hFFFF) begin
                    stall_exp++;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_word  = {bus.out_last, bus.out_data};
                done_pend  = done_nxt;
            end
        end
    end

    // -------------------------------------------------------------- helpers
    task automatic send_cmd(input int a, input int l);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = AW'(a);
        bus.cmd_len   = (AW + 1)'(l);
        @(posedge clk);  // accepted at this edge (reader is idle)
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((active || done_pend) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic randomize_ram();
        for (int i = 0; i < RAM_SIZE; i++) ram[i] = DW'($urandom);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        logic [AW-1:0] addr_before;
        int            seq_62 [4];
        int            len;

        seq_62 = '{62, 63, 0, 1};
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        for (int i = 0; i < RAM_SIZE; i++) ram[i] = DW'(i);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // 1: addr 5, len 4, RAM[i]=i, consumer always ready
        rdy_mode = 1;
        send_cmd(5, 4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 4) begin
                check("t1_latency_valid", 32'(bus.out_valid), 32'd0);
            end else if (k <= 7) begin
                check("t1_valid", 32'(bus.out_valid), 32'd1);
                check("t1_data",  32'(bus.out_data), 32'(k + 1));
                check("t1_last",  32'(bus.out_last), (k == 7) ? 32'd1 : 32'd0);
            end else begin
                check("t1_done", 32'(bus.done), 32'd1);
            end
        end
        wait_done("t1");

        // 2: address wrap 62,63,0,1
        randomize_ram();
        send_cmd(62, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_mem_addr", 32'(bus.mem_addr), 32'(seq_62[k]));
        end
        wait_done("t2");

        // 3: full-size burst against a randomly stalling consumer
        randomize_ram();
        rdy_mode = 2;
        send_cmd(int'($urandom_range(0, RAM_SIZE - 1)), RAM_SIZE);
        wait_done("t3");
        check("t3_word_count", 32'(popped), 32'(RAM_SIZE));

        // 4: long stall mid-burst; issue must stop with DEPTH words outstanding
        randomize_ram();
        rdy_mode = 1;
        send_cmd(10, 40);
        repeat (8) @(negedge clk);
        rdy_mode = 0;
        repeat (20) @(negedge clk);
        check("t4_stall_valid", 32'(bus.out_valid), 32'd1);
        check("t4_stall_addr", 32'(bus.mem_addr),
              32'((10 + ((popped + DEPTH < 40) ? popped + DEPTH : 40)) % RAM_SIZE));
`ifdef RAM_STREAM_READER_STALL_CNT_EN
        check("t4_stall_cnt_min", (stall_cycles >= 16'd19) ? 32'd1 : 32'd0, 32'd1);
`endif
        rdy_mode = 1;
        wait_done("t4");
        check("t4_word_count", 32'(popped), 32'd40);

        // 5: zero-length command
        addr_before = bus.mem_addr;
        send_cmd(33, 0);
        @(negedge clk);
        check("t5_done", 32'(bus.done), 32'd1);
        check("t5_mem_addr", 32'(bus.mem_addr), 32'(addr_before));
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        wait_done("t5");

        // 6: reset while words are buffered, then a clean burst
        randomize_ram();
        rdy_mode = 0;
        send_cmd(20, 10);
        repeat (6) @(negedge clk);
        check("t6_buffered_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("t6_rst_busy",      32'(bus.busy),      32'd0);
        check("t6_rst_done",      32'(bus.done),      32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        rdy_mode = 2;
        send_cmd(50, 20);
        wait_done("t6");
        check("t6_word_count", 32'(popped), 32'd20);

        // Random bursts
        for (int b = 0; b < 6; b++) begin
            randomize_ram();
            rdy_mode = 2;
            len = int'($urandom_range(1, RAM_SIZE));
            send_cmd(int'($urandom_range(0, RAM_SIZE - 1)), len);
            wait_done("rand");
            check("rand_word_count", 32'(popped), 32'(len));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
